// File: rtl/fetch_pkg.sv
// Shared widths, bubble encoding and fetch FSM state codes for the IF stage.
package fetch_pkg;

  localparam int FETCH_ADDR_SIZE  = 32;
  localparam int FETCH_INSTR_SIZE = 32;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_1000;

  localparam logic [6:0]                  FETCH_OPCODE_NOP = 7'h00;
  localparam logic [FETCH_INSTR_SIZE-1:0] FETCH_NOP_INSTR  = {25'h0, FETCH_OPCODE_NOP};

  localparam logic [1:0] FETCH_S_REQ  = 2'd0;
  localparam logic [1:0] FETCH_S_HOLD = 2'd1;
  localparam logic [1:0] FETCH_S_KILL = 2'd2;

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer catching an instruction that returns while decode is stalled.
module fetch_skid
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = FETCH_ADDR_SIZE,
  parameter int INSTR_W = FETCH_INSTR_SIZE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               drain_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               valid_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [INSTR_W-1:0] instr_o
);

  logic               valid_q;
  logic [ADDR_W-1:0]  pc_q;
  logic [INSTR_W-1:0] instr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       valid_q <= 1'b0;
    else if (load_i)  valid_q <= 1'b1;
    else if (drain_i) valid_q <= 1'b0;
  end

  // NOTE: payload registers carry no reset; valid_q alone says whether they mean anything.
  always_ff @(posedge clk) begin
    if (load_i) begin
      pc_q    <= pc_i;
      instr_q <= instr_i;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_top.sv
// Instruction fetch: sequential PC generation, imem req/ack handshake and IF/ID register.
module fetch_top
  import fetch_pkg::*;
#(
  parameter int                     ADDR_SIZE  = FETCH_ADDR_SIZE,
  parameter int                     INSTR_SIZE = FETCH_INSTR_SIZE,
  parameter logic [ADDR_SIZE-1:0]   RESET_PC   = ADDR_SIZE'(FETCH_RESET_PC),
  parameter logic [INSTR_SIZE-1:0]  NOP_INSTR  = FETCH_NOP_INSTR
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pc_write,
  input  logic                  if_id_write,
  input  logic                  branch_taken,
  input  logic [ADDR_SIZE-1:0]  branch_target,
  output logic                  imem_req,
  output logic [ADDR_SIZE-1:0]  imem_addr,
  input  logic                  imem_ack,
  input  logic [INSTR_SIZE-1:0] imem_data,
  output logic [ADDR_SIZE-1:0]  pc,
  output logic [INSTR_SIZE-1:0] instruction
);

  logic [1:0]            state_q, state_d;
  logic [ADDR_SIZE-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_SIZE-1:0]  req_addr_q, req_addr_d;
  logic [ADDR_SIZE-1:0]  pc_q, pc_d;
  logic [INSTR_SIZE-1:0] instr_q, instr_d;

  logic                  stall, ack;
  logic                  hold_load, hold_drain, hold_valid;
  logic [ADDR_SIZE-1:0]  hold_pc, req_inc, hold_inc;
  logic [INSTR_SIZE-1:0] hold_instr;

  assign stall    = ~pc_write | ~if_id_write;
  assign imem_req = (state_q == FETCH_S_REQ) | (state_q == FETCH_S_KILL);
  assign ack      = imem_req & imem_ack;
  assign req_inc  = req_addr_q + ADDR_SIZE'(4);
  assign hold_inc = hold_pc + ADDR_SIZE'(4);

  fetch_skid #(.ADDR_W(ADDR_SIZE), .INSTR_W(INSTR_SIZE)) u_skid (
    .clk     (clk),
    .rst_n   (reset),
    .load_i  (hold_load),
    .drain_i (hold_drain),
    .pc_i    (req_addr_q),
    .instr_i (imem_data),
    .valid_o (hold_valid),
    .pc_o    (hold_pc),
    .instr_o (hold_instr)
  );

  // NOTE: every variable assigned here gets a default first, so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    hold_load  = 1'b0;
    hold_drain = 1'b0;
    case (state_q)
      FETCH_S_REQ: begin
        if (branch_taken) begin
          fetch_pc_d = branch_target;
          pc_d       = branch_target;
          instr_d    = NOP_INSTR;
          // Without ack the old request is still live on the bus; retarget once it completes.
          if (ack) req_addr_d = branch_target;
          else     state_d    = FETCH_S_KILL;
        end else if (ack && !stall) begin
          pc_d       = req_addr_q;
          instr_d    = imem_data;
          fetch_pc_d = req_inc;
          req_addr_d = req_inc;
        end else if (ack) begin
          hold_load = 1'b1;
          state_d   = FETCH_S_HOLD;
        end else if (!stall) begin
          pc_d    = req_addr_q;
          instr_d = NOP_INSTR;
        end
      end
      FETCH_S_HOLD: begin
        if (branch_taken) begin
          hold_drain = 1'b1;
          fetch_pc_d = branch_target;
          req_addr_d = branch_target;
          pc_d       = branch_target;
          instr_d    = NOP_INSTR;
          state_d    = FETCH_S_REQ;
        end else if (!stall && hold_valid) begin
          hold_drain = 1'b1;
          pc_d       = hold_pc;
          instr_d    = hold_instr;
          fetch_pc_d = hold_inc;
          req_addr_d = hold_inc;
          state_d    = FETCH_S_REQ;
        end
      end
      FETCH_S_KILL: begin
        if (branch_taken) begin
          fetch_pc_d = branch_target;
          pc_d       = branch_target;
          instr_d    = NOP_INSTR;
        end else if (!stall) begin
          pc_d    = fetch_pc_q;
          instr_d = NOP_INSTR;
        end
        if (ack) begin
          req_addr_d = branch_taken ? branch_target : fetch_pc_q;
          state_d    = FETCH_S_REQ;
        end
      end
      default: state_d = FETCH_S_REQ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FETCH_S_REQ;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
    end
  end

  assign imem_addr   = req_addr_q;
  assign pc          = pc_q;
  assign instruction = instr_q;

endmodule

// File: tb/tb_fetch_top.sv
// Self-checking bench for fetch_top: directed scenarios plus randomized traffic vs a transaction model.
module tb_fetch_top;

  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pc_write = 1'b1;
  logic        if_id_write = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] instruction;

  always #5 clk = ~clk;

  // Memory image: each word is its address xor 0xA5, never equal to the bubble encoding.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0000_00A5;
  endfunction

  assign imem_data = mem_word(imem_addr);

  fetch_top dut (
    .clk           (clk),
    .reset         (reset),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_data     (imem_data),
    .pc            (pc),
    .instruction   (instruction)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: the request on the bus, whether it is orphaned by a
  // redirect, where fetching resumes, and any instruction parked during a stall.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  ifid_t       m_ifid;
  ifid_t       m_parked[$];
  logic [31:0] m_addr;
  logic [31:0] m_resume;
  bit          m_orphan;

  function automatic bit m_req();
    return m_parked.size() == 0;
  endfunction

  task automatic model_reset();
    m_ifid   = '{pc: RST_PC, instr: NOP};
    m_parked.delete();
    m_addr   = RST_PC;
    m_resume = RST_PC;
    m_orphan = 1'b0;
  endtask

  task automatic model_next(input bit ack_in, input bit stall, input bit br, input logic [31:0] tgt);
    bit    done;
    ifid_t item;
    done = m_req() && ack_in;
    if (!m_req()) begin
      if (br) begin
        m_parked.delete();
        m_addr = tgt;
        m_ifid = '{pc: tgt, instr: NOP};
      end else if (!stall) begin
        item   = m_parked.pop_front();
        m_ifid = item;
        m_addr = item.pc + 32'd4;
      end
    end else if (m_orphan) begin
      if (br) begin
        m_resume = tgt;
        m_ifid   = '{pc: tgt, instr: NOP};
      end else if (!stall) begin
        m_ifid = '{pc: m_resume, instr: NOP};
      end
      if (done) begin
        m_orphan = 1'b0;
        m_addr   = m_resume;
      end
    end else begin
      if (br) begin
        m_ifid = '{pc: tgt, instr: NOP};
        if (done) m_addr = tgt;
        else begin
          m_orphan = 1'b1;
          m_resume = tgt;
        end
      end else if (done && !stall) begin
        m_ifid = '{pc: m_addr, instr: mem_word(m_addr)};
        m_addr = m_addr + 32'd4;
      end else if (done) begin
        m_parked.push_back('{pc: m_addr, instr: mem_word(m_addr)});
      end else if (!stall) begin
        m_ifid = '{pc: m_addr, instr: NOP};
      end
    end
  endtask

  task automatic compare_all();
    check("imem_req", {31'b0, imem_req}, {31'b0, m_req()});
    if (m_req()) check("imem_addr", imem_addr, m_addr);
    check("pc", pc, m_ifid.pc);
    check("instruction", instruction, m_ifid.instr);
  endtask

  // Called at a negedge: compare, drive one cycle of inputs, advance model and clock.
  task automatic step(input bit ack_in, input bit stall, input bit br, input logic [31:0] tgt);
    compare_all();
    imem_ack      = ack_in;
    pc_write      = !stall;
    if_id_write   = !stall;
    branch_taken  = br;
    branch_target = tgt;
    model_next(ack_in, stall, br, tgt);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    imem_ack     = 1'b0;
    branch_taken = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    reset        = 1'b0;
    #1;
    check({tag, "_pc"}, pc, RST_PC);
    check({tag, "_instr"}, instruction, NOP);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    check({tag, "_req"}, {31'b0, imem_req}, 32'd1);
    check({tag, "_addr"}, imem_addr, RST_PC);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset("por");

    // Zero-wait streaming
    step(1, 0, 0, 0);
    check("s1_addr", imem_addr, 32'h1004);
    check("s1_pc", pc, 32'h1000);
    check("s1_instr", instruction, 32'h10A5);
    step(1, 0, 0, 0);
    check("s1_addr2", imem_addr, 32'h1008);
    check("s1_instr2", instruction, 32'h10A1);

    // Ack on 0x1008 under a two-cycle stall
    step(1, 1, 0, 0);
    check("s3_req_off", {31'b0, imem_req}, 32'd0);
    check("s3_pc_hold", pc, 32'h1004);
    step(0, 1, 0, 0);
    check("s3_pc_hold2", pc, 32'h1004);
    step(0, 0, 0, 0);
    check("s3_pc", pc, 32'h1008);
    check("s3_instr", instruction, 32'h10AD);
    check("s3_next", imem_addr, 32'h100C);

    // Ack every third cycle: bubbles while waiting
    for (int i = 0; i < 9; i++) step(i % 3 == 2, 0, 0, 0);
    check("s2_addr", imem_addr, 32'h1018);
    check("s2_pc", pc, 32'h1014);

    // Redirect while a request is outstanding
    step(0, 0, 1, 32'h2000);
    check("s4_pc", pc, 32'h2000);
    check("s4_instr", instruction, NOP);
    check("s4_addr_old", imem_addr, 32'h1018);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    check("s4_addr_tgt", imem_addr, 32'h2000);
    check("s4_bubble", instruction, NOP);
    step(1, 0, 0, 0);
    check("s4_pc2", pc, 32'h2000);
    check("s4_instr2", instruction, 32'h20A5);

    // Branch under stall, then a second redirect while orphaned
    step(0, 1, 1, 32'h2000);
    check("s5_pc", pc, 32'h2000);
    step(0, 0, 1, 32'h3000);
    step(1, 0, 0, 0);
    check("s5_addr", imem_addr, 32'h3000);
    step(1, 0, 0, 0);
    check("s5_instr", instruction, 32'h30A5);

    // Reset in the middle of an orphaned request and of a parked instruction
    step(0, 0, 1, 32'h4000);
    do_reset("rst_kill");
    step(1, 1, 0, 0);
    do_reset("rst_hold");

    // Address wrap at the top of memory
    step(1, 0, 1, 32'hFFFF_FFFC);
    check("wrap_tgt", imem_addr, 32'hFFFF_FFFC);
    step(1, 0, 0, 0);
    check("wrap_addr", imem_addr, 32'h0000_0000);
    check("wrap_instr", instruction, 32'hFFFF_FF59);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      logic [31:0] tgt;
      tgt = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) tgt = 32'hFFFF_FFF8;
      step($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
           $urandom_range(0, 11) == 0, tgt);
      if ($urandom_range(0, 499) == 0) do_reset("rnd_rst");
    end
    compare_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
